// File: rtl/soc_irq_gen_if.sv
// Request/finish bundle between the peripheral event side, the interrupt
// controller and the soc_irq_gen requester.
interface soc_irq_gen_if #(
  parameter int NUM_SRC = 32
);
  logic [NUM_SRC-1:0] ev_i;
  logic [NUM_SRC-1:0] ev_en_i;
  logic [NUM_SRC-1:0] int_fin_i;
  logic [NUM_SRC-1:0] ovf_clr_i;
  logic [NUM_SRC-1:0] int_req_o;
  logic [NUM_SRC-1:0] pend_o;
  logic [NUM_SRC-1:0] ovf_o;

  modport master (
    output ev_i, ev_en_i, int_fin_i, ovf_clr_i,
    input  int_req_o, pend_o, ovf_o
  );

  modport slave (
    input  ev_i, ev_en_i, int_fin_i, ovf_clr_i,
    output int_req_o, pend_o, ovf_o
  );
endinterface

// File: rtl/soc_irq_gen.sv
// Interrupt requester: synchronises peripheral events, counts them per source
// and holds a level request until the controller returns a finish pulse.
module soc_irq_gen #(
  parameter int NUM_SRC = 32,
  parameter int CNT_W   = 4,
  parameter int SYNC    = 2
) (
  input  logic         clk,
  input  logic         rstn,
  soc_irq_gen_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  logic [NUM_SRC-1:0] ev_s;
  logic [NUM_SRC-1:0] ev_d_q;
  logic [NUM_SRC-1:0] edge_q;
  logic [NUM_SRC-1:0] ovf_q;
  logic [NUM_SRC-1:0] ovf_d;
  logic [NUM_SRC-1:0] pend_q;
  logic [NUM_SRC-1:0] req_q;
  logic [CNT_W-1:0]   cnt_q [NUM_SRC];
  logic [CNT_W-1:0]   cnt_d [NUM_SRC];
  state_e             state_q [NUM_SRC];

  generate
    if (SYNC == 0) begin : g_nosync
      assign ev_s = bus.ev_i;
    end else begin : g_sync
      logic [NUM_SRC-1:0] sync_q [SYNC];

      // Synchroniser chain bringing the raw event lines into the clk domain.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int k = 0; k < SYNC; k++) begin
            sync_q[k] <= {NUM_SRC{1'b0}};
          end
        end else begin
          sync_q[0] <= bus.ev_i;
          for (int k = 1; k < SYNC; k++) begin
            sync_q[k] <= sync_q[k-1];
          end
        end
      end

      assign ev_s = sync_q[SYNC-1];
    end
  endgenerate

  // Rising-edge detector; the registered pulse gives SYNC+1 cycles of latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ev_d_q <= {NUM_SRC{1'b0}};
      edge_q <= {NUM_SRC{1'b0}};
    end else begin
      ev_d_q <= ev_s;
      edge_q <= ev_s & ~ev_d_q & bus.ev_en_i;
    end
  end

  // Saturating pending counters and sticky overflow; set beats clear.
  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      logic dec_v;
      logic inc_only_v;
      dec_v      = bus.int_fin_i[i] & (state_q[i] == ST_REQ);
      inc_only_v = edge_q[i] & ~dec_v;
      cnt_d[i]   = cnt_q[i];
      if (inc_only_v) begin
        if (cnt_q[i] != CNT_MAX) begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end else begin
          cnt_d[i] = cnt_q[i];
        end
      end else if (dec_v & ~edge_q[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
      ovf_d[i] = (inc_only_v & (cnt_q[i] == CNT_MAX)) | (ovf_q[i] & ~bus.ovf_clr_i[i]);
    end
  end

  // Per-source request FSM with registered request, pending and overflow outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= CNT_ZERO;
      end
      req_q  <= {NUM_SRC{1'b0}};
      pend_q <= {NUM_SRC{1'b0}};
      ovf_q  <= {NUM_SRC{1'b0}};
    end else begin
      ovf_q <= ovf_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        cnt_q[i]  <= cnt_d[i];
        pend_q[i] <= (cnt_d[i] != CNT_ZERO);
        case (state_q[i])
          ST_IDLE: begin
            if (cnt_d[i] != CNT_ZERO) begin
              state_q[i] <= ST_REQ;
              req_q[i]   <= 1'b1;
            end else begin
              state_q[i] <= ST_IDLE;
              req_q[i]   <= 1'b0;
            end
          end
          ST_REQ: begin
            if (bus.int_fin_i[i]) begin
              state_q[i] <= ST_GAP;
              req_q[i]   <= 1'b0;
            end else begin
              state_q[i] <= ST_REQ;
              req_q[i]   <= 1'b1;
            end
          end
          ST_GAP: begin
            // Looks at the settled count so the low cycle is always exactly one.
            if (cnt_q[i] != CNT_ZERO) begin
              state_q[i] <= ST_REQ;
              req_q[i]   <= 1'b1;
            end else begin
              state_q[i] <= ST_IDLE;
              req_q[i]   <= 1'b0;
            end
          end
          default: begin
            state_q[i] <= ST_IDLE;
            req_q[i]   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.int_req_o = req_q;
  assign bus.pend_o    = pend_q;
  assign bus.ovf_o     = ovf_q;

endmodule

// File: tb/tb_soc_irq_gen.sv
// Directed plus randomised bench for soc_irq_gen against a per-source
// event-count reference model.
module tb_soc_irq_gen;
  localparam int NUM_SRC = 32;
  localparam int CNT_W   = 4;
  localparam int SYNC    = 2;
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam int M_IDLE  = 0;
  localparam int M_REQ   = 1;
  localparam int M_GAP   = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  soc_irq_gen_if #(.NUM_SRC(NUM_SRC)) bus_if ();

  soc_irq_gen #(.NUM_SRC(NUM_SRC), .CNT_W(CNT_W), .SYNC(SYNC)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_if)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: event count, service mode and overflow flag per source,
  // plus the history of sampled event lines (index j = sampled j edges ago).
  int                 cnt_m  [NUM_SRC];
  int                 mode_m [NUM_SRC];
  logic [NUM_SRC-1:0] ovf_m;
  logic [NUM_SRC-1:0] evh    [SYNC+3];
  logic [NUM_SRC-1:0] en_prev;

  task automatic chk(input string tag, input logic [NUM_SRC-1:0] obs, input logic [NUM_SRC-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_SRC; i++) begin
      cnt_m[i]  = 0;
      mode_m[i] = M_IDLE;
    end
    for (int j = 0; j < SYNC + 3; j++) evh[j] = '0;
    ovf_m   = '0;
    en_prev = '0;
  endtask

  // An event counts when the line sampled SYNC+1 edges ago is high, the one
  // before it was low, and the source was enabled one edge ago.
  task automatic model_edge();
    logic [NUM_SRC-1:0] inc_v;
    inc_v = evh[SYNC+1] & ~evh[SYNC+2] & en_prev;
    for (int i = 0; i < NUM_SRC; i++) begin
      int  old;
      bit  dec;
      bit  sat_hit;
      old     = cnt_m[i];
      dec     = bus_if.int_fin_i[i] && (mode_m[i] == M_REQ);
      sat_hit = inc_v[i] && !dec && (old == CMAX);
      if (inc_v[i] && !dec && old < CMAX) cnt_m[i] = old + 1;
      if (dec && !inc_v[i]) cnt_m[i] = old - 1;
      if (sat_hit) ovf_m[i] = 1'b1;
      else if (bus_if.ovf_clr_i[i]) ovf_m[i] = 1'b0;
      case (mode_m[i])
        M_IDLE:  if (cnt_m[i] > 0) mode_m[i] = M_REQ;
        M_REQ:   if (bus_if.int_fin_i[i]) mode_m[i] = M_GAP;
        default: mode_m[i] = (old > 0) ? M_REQ : M_IDLE;
      endcase
    end
    for (int j = SYNC + 2; j >= 2; j--) evh[j] = evh[j-1];
    evh[1]  = bus_if.ev_i;
    en_prev = bus_if.ev_en_i;
  endtask

  task automatic check_outputs(input string tag);
    logic [NUM_SRC-1:0] req_e;
    logic [NUM_SRC-1:0] pend_e;
    for (int i = 0; i < NUM_SRC; i++) begin
      req_e[i]  = (mode_m[i] == M_REQ);
      pend_e[i] = (cnt_m[i] != 0);
    end
    chk({tag, ".req"},  bus_if.int_req_o, req_e);
    chk({tag, ".pend"}, bus_if.pend_o,    pend_e);
    chk({tag, ".ovf"},  bus_if.ovf_o,     ovf_m);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (rstn) model_edge();
    else model_reset();
    #1;
    check_outputs(tag);
  endtask

  task automatic steps(input int n, input string tag);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  task automatic wait_req(input int src, input string tag);
    int n;
    n = 0;
    while (bus_if.int_req_o[src] !== 1'b1 && n < 40) begin
      step(tag);
      n++;
    end
    chkb({tag, ".req_timeout"}, bus_if.int_req_o[src], 1'b1);
  endtask

  task automatic finish_pulse(input int src, input string tag);
    bus_if.int_fin_i[src] = 1'b1;
    step(tag);
    bus_if.int_fin_i[src] = 1'b0;
  endtask

  initial begin
    bus_if.ev_i      = '0;
    bus_if.ev_en_i   = '1;
    bus_if.int_fin_i = '0;
    bus_if.ovf_clr_i = '0;
    model_reset();
    #2 rstn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs("reset");
    chk("reset.req_zero", bus_if.int_req_o, '0);
    rstn = 1'b1;
    steps(2, "idle");

    // Single event on source 3: request after SYNC+1 edges.
    bus_if.ev_i[3] = 1'b1;
    steps(3, "single.lat");
    chkb("single.req_early", bus_if.int_req_o[3], 1'b0);
    step("single.rise");
    chkb("single.req_rise", bus_if.int_req_o[3], 1'b1);
    chkb("single.pend", bus_if.pend_o[3], 1'b1);
    bus_if.ev_i[3] = 1'b0;
    finish_pulse(3, "single.fin");
    chkb("single.gap", bus_if.int_req_o[3], 1'b0);
    step("single.idle");
    chkb("single.idle_req", bus_if.int_req_o[3], 1'b0);
    chkb("single.idle_pend", bus_if.pend_o[3], 1'b0);

    // Three queued events on source 0.
    for (int k = 0; k < 3; k++) begin
      bus_if.ev_i[0] = 1'b1;
      step("queue.ev");
      bus_if.ev_i[0] = 1'b0;
      step("queue.ev");
    end
    steps(SYNC + 2, "queue.settle");
    for (int k = 0; k < 3; k++) begin
      wait_req(0, "queue.wait");
      finish_pulse(0, "queue.fin");
      chkb("queue.gap_low", bus_if.int_req_o[0], 1'b0);
    end
    steps(3, "queue.drain");
    chkb("queue.final_req", bus_if.int_req_o[0], 1'b0);
    chkb("queue.final_pend", bus_if.pend_o[0], 1'b0);

    // Saturation on source 5: 17 edges, no finish.
    for (int k = 0; k < 17; k++) begin
      bus_if.ev_i[5] = 1'b1;
      step("sat.ev");
      bus_if.ev_i[5] = 1'b0;
      step("sat.ev");
    end
    steps(SYNC + 2, "sat.settle");
    chkb("sat.ovf_set", bus_if.ovf_o[5], 1'b1);
    bus_if.ovf_clr_i[5] = 1'b1;
    step("sat.clr");
    bus_if.ovf_clr_i[5] = 1'b0;
    chkb("sat.ovf_cleared", bus_if.ovf_o[5], 1'b0);
    for (int k = 0; k < CMAX; k++) begin
      wait_req(5, "sat.wait");
      finish_pulse(5, "sat.fin");
    end
    steps(3, "sat.drain");
    chkb("sat.final_req", bus_if.int_req_o[5], 1'b0);
    chkb("sat.final_pend", bus_if.pend_o[5], 1'b0);

    // Event and finish in the same cycle on source 7.
    bus_if.ev_i[7] = 1'b1;
    wait_req(7, "simul.wait");
    bus_if.ev_i[7] = 1'b0;
    steps(2, "simul.low");
    bus_if.ev_i[7] = 1'b1;
    steps(SYNC + 1, "simul.prop");
    finish_pulse(7, "simul.both");
    chkb("simul.gap_req", bus_if.int_req_o[7], 1'b0);
    chkb("simul.gap_pend", bus_if.pend_o[7], 1'b1);
    step("simul.back");
    chkb("simul.req_back", bus_if.int_req_o[7], 1'b1);
    bus_if.ev_i[7] = 1'b0;
    finish_pulse(7, "simul.drain");
    steps(2, "simul.idle");
    chkb("simul.final_req", bus_if.int_req_o[7], 1'b0);

    // Disabled source and stray finish on source 2.
    bus_if.ev_en_i[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus_if.ev_i[2] = 1'b1;
      step("en.ev");
      bus_if.ev_i[2] = 1'b0;
      step("en.ev");
    end
    steps(SYNC + 2, "en.settle");
    chkb("en.no_req", bus_if.int_req_o[2], 1'b0);
    chkb("en.no_pend", bus_if.pend_o[2], 1'b0);
    finish_pulse(2, "en.stray_fin");
    step("en.after");
    bus_if.ev_en_i[2] = 1'b1;

    // Asynchronous reset with requests and overflow outstanding.
    bus_if.ev_i[1] = 1'b1;
    for (int k = 0; k < 17; k++) begin
      bus_if.ev_i[9]  = 1'b1;
      bus_if.ev_i[10] = 1'b1;
      step("arst.ev");
      bus_if.ev_i[9]  = 1'b0;
      bus_if.ev_i[10] = 1'b0;
      step("arst.ev");
    end
    steps(SYNC + 2, "arst.settle");
    chkb("arst.pre_ovf", bus_if.ovf_o[9], 1'b1);
    chkb("arst.pre_req", bus_if.int_req_o[1], 1'b1);
    bus_if.ev_i = '0;
    #3 rstn = 1'b0;
    #1;
    chk("arst.req_async",  bus_if.int_req_o, '0);
    chk("arst.pend_async", bus_if.pend_o,    '0);
    chk("arst.ovf_async",  bus_if.ovf_o,     '0);
    model_reset();
    step("arst.hold");
    rstn = 1'b1;
    steps(6, "arst.post");
    chk("arst.no_req_after", bus_if.int_req_o, '0);

    // Randomised traffic including stray finishes and disabled sources.
    for (int c = 0; c < 500; c++) begin
      bus_if.ev_i      = bus_if.ev_i ^ ($urandom() & $urandom() & $urandom());
      bus_if.int_fin_i = $urandom() & $urandom();
      bus_if.ovf_clr_i = $urandom() & $urandom() & $urandom() & $urandom();
      if (c % 50 == 0) bus_if.ev_en_i = ~($urandom() & $urandom() & $urandom());
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/soc_irq_gen.md
Name: soc_irq_gen

Overview:
- Peripheral-side interrupt request generator: the requester end of the interrupt controller's request/finish handshake.
- Converts raw peripheral event lines into level requests on int_req. Each request is held until the controller returns a one-cycle finish pulse for that source.
- Counts events that arrive while a request is outstanding, so no event is lost.
- Sits between the SoC peripherals (timer, UART, GPIO) and the interrupt controller.

Parameters:
- NUM_SRC, 32, number of sources; must match the controller request/finish width.
- CNT_W, 4, width of each per-source pending-event counter; saturates at 2^CNT_W-1.
- SYNC, 2, number of synchroniser flops on ev_i; legal values 0..3. 0 means ev_i is already in the clk domain.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous, active-low reset.
- ev_i  in  NUM_SRC  raw peripheral event lines; a rising edge is one event.
- ev_en_i  in  NUM_SRC  per-source event enable; edges on a disabled source are dropped.
- int_fin_i  in  NUM_SRC  one-cycle pulse from the controller: service of that source is complete.
- int_req_o  out  NUM_SRC  registered level request to the controller.
- pend_o  out  NUM_SRC  per-source flag, high when that source's pending counter is non-zero.
- ovf_o  out  NUM_SRC  sticky overflow flag: an event arrived while that source's counter was saturated.
- ovf_clr_i  in  NUM_SRC  per-source clear of ovf_o; takes effect on the next clock edge.

Behaviour:
- Reset (rstn low, asynchronous): all synchroniser stages, the edge-history register, counters, FSMs, int_req_o, pend_o and ovf_o go to 0. Events already in flight are discarded.
- Input path: ev_i passes through SYNC flops, then edge detection. ev_s is the synchronised value and ev_d is ev_s delayed one cycle. edge = ev_s & ~ev_d & ev_en_i. Falling edges and static levels produce nothing.
- Latency: int_req_o rises SYNC+1 clock edges after the edge at which ev_i is first sampled high, provided the source FSM is IDLE.
- Counter update per source, each cycle:
  - inc = edge; dec = int_fin_i & (state==REQ).
  - inc & ~dec: cnt+1, saturating. If cnt is already at max, cnt holds and ovf_o is set.
  - dec & ~inc: cnt-1.
  - inc & dec: cnt unchanged.
- ovf_o: set has priority over ovf_clr_i in the same cycle.
- pend_o = (cnt != 0), registered.
- Per-source FSM:
  - IDLE (req=0): move to REQ when the next counter value is non-zero.
  - REQ (req=1): on int_fin_i go to GAP and decrement the counter. Otherwise stay.
  - GAP (req=0, exactly one cycle): go to REQ if cnt>0, else IDLE.
- Purpose of GAP: guarantees a low cycle on int_req_o between back-to-back services, so the controller's request edge logic sees a new request.
- int_req_o is driven directly from the state register (REQ -> 1), with no combinational path from any input.
- int_fin_i received in IDLE or GAP is ignored: no counter change, no state change.
- Disabling a source (ev_en_i low) while it is in REQ or has pending events: the current request and pending count are kept. Only new edges are blocked.
- Sources are fully independent. Simultaneous events and finishes on different sources are each handled in the same cycle.
- Counter arithmetic is unsigned CNT_W bits and never wraps in either direction. Underflow cannot occur because dec requires REQ, and REQ implies cnt>=1.

Test Plan:
- Reset and single event: SYNC=2, source 3 ev_i 0->1 at edge 0. int_req_o[3]=1 after edge 3, pend_o[3]=1. Pulse int_fin_i[3]. Next cycle int_req_o[3]=0 (GAP), then IDLE; pend_o[3]=0.
- Queued events: 3 rising edges on source 0 before any finish gives cnt=3. Each int_fin_i[0] pulse produces exactly one low GAP cycle, then req returns high. After the third finish, req stays 0.
- Saturation: CNT_W=4, 17 edges on source 5 with no finish. Counter holds at 15 and ovf_o[5]=1. Pulse ovf_clr_i[5] and ovf_o[5]=0. A 16th finish is not required: after 15 finishes, req=0.
- Simultaneous inc/dec: edge on source 7 in the same cycle as int_fin_i[7] with cnt=1. cnt stays 1, FSM goes REQ->GAP->REQ, and req is low for exactly one cycle.
- Enable and stray finish: ev_en_i[2]=0 with edges on ev_i[2] gives no req and pend_o[2]=0. int_fin_i[2] pulsed in IDLE changes nothing.
- Asynchronous reset mid-operation: rstn low between clock edges with req and ovf high on several sources. All outputs drop to 0 immediately without a clock. After release, no request appears until a new rising edge arrives.
